mult_16: RTL and testbench
==========================

Name: mult_16

Overview:
- Sequential shift-and-add unsigned multiplier. It is the inverse companion of the team's shift-subtract divider div_16.
- Computes result = A * B over WIDTH iterations, one multiplier bit per cycle.
- Uses the same start/done handshake as the divider, so the two blocks can be used interchangeably by the same control sequencer.

Parameters:
- WIDTH, 16, operand width in bits; result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- init_in  input  1  start request; sampled only in IDLE.
- A  input  WIDTH  multiplicand; captured on accepted start.
- B  input  WIDTH  multiplier; captured on accepted start.
- result  output  2*WIDTH  product register; holds the last completed product.
- done  output  1  one-cycle pulse; result is valid from this cycle onward.
- busy  output  1  high while an operation is in progress (RUN state).

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - State returns to IDLE.
  - result = 0, done = 0, busy = 0.
  - Internal acc, mcand, mplr and cnt are cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- Internal registers:
  - acc: 2*WIDTH bits.
  - mcand: 2*WIDTH bits, loaded with A zero-extended.
  - mplr: WIDTH bits.
  - cnt: $clog2(WIDTH+1) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - done = 0, busy = 0.
  - If init_in = 1: load mcand = {0, A}, mplr = B, acc = 0, cnt = WIDTH; go to RUN.
  - Cycle numbering: this is cycle 0.
- RUN (busy = 1), each cycle:
  - If mplr[0] = 1, acc <= acc + mcand. The sum is 2*WIDTH bits and never overflows.
  - Then mcand <= mcand << 1, mplr <= mplr >> 1, cnt <= cnt - 1.
  - When cnt = 1 in this cycle (last iteration): result <= final acc value including this cycle's add; go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0.
  - Go to IDLE unconditionally.
  - init_in is ignored in DONE; a start asserted here is accepted in the following IDLE cycle.
- Latency: done high at cycle WIDTH+1 (17 for the default WIDTH). Start-to-start throughput is WIDTH+2 cycles.
- init_in in RUN or DONE: ignored. A and B changes after capture have no effect.
- result is stable outside the DONE-entry update and is never cleared by a new start.
- Zero operands need no special case; the product is 0 with full latency.
- init_in held high continuously: back-to-back operations, each restarting in IDLE.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined:
  - In RUN, also finish when the shifted mplr becomes 0 (mplr >> 1 == 0) after this cycle's iteration.
  - result <= final acc; go to DONE.
  - Latency = (index of highest set bit of B) + 2 cycles; minimum 2 (B = 0 or 1), maximum WIDTH+1.
- Undefined: fixed latency WIDTH+1 for all operands.
- Result values are identical either way.

Decomposition:
- Package mult_pkg:
  - state typedef (IDLE, RUN, DONE) with 2-bit encoding.
  - Default WIDTH constant.
  - Function computing the cnt width.
- Natural sub-module: control_mult.
  - Contains the FSM, cnt, and the done/busy generation.
  - Drives load/shift/add_en strobes to the datapath (acc/mcand/mplr/result), which stays in mult_16.

Test Plan:
- Basic: A = 3, B = 5, init_in pulse at cycle 0 -> busy high cycles 1-16; done pulse at cycle 17 only; result = 0x0000000F, held after done.
- Max: A = 0xFFFF, B = 0xFFFF -> result = 0xFFFE0001 at cycle 17; no overflow.
- Zero, then back-to-back:
  - A = 0x1234, B = 0 -> result = 0.
  - Then init_in held high: the next operation starts in the IDLE cycle after DONE.
  - A = 0x0100, B = 0x0100 -> result = 0x00010000; done pulses 18 cycles apart.
- Start ignored while busy: A = 7, B = 9, start; at cycle 5 drive init_in = 1 with A = 2, B = 2 -> result = 63 (0x3F) at cycle 17; no extra done pulse.
- Reset mid-op: start A = 0xAAAA, B = 0x5555; assert rst at cycle 8 for 1 cycle -> next cycle result = 0, done = 0, busy = 0, state IDLE; no done pulse; a fresh start then works normally.
- MULT_EARLY_EXIT_EN:
  - A = 2, B = 1 -> done at cycle 2, result = 2.
  - A = 5, B = 0x8000 -> done at cycle 17, result = 0x00028000.
  - Without the macro, both cases complete at cycle 17.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the mult_16 shift-and-add multiplier.
//   state_e       : controller FSM state (IDLE, RUN, DONE), 2-bit encoding
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : width of the iteration counter for a given operand width
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_16_if.sv
// mult_16_if: start/done handshake and operand/result bus for mult_16.
//   init_in : start request (sampled only while the multiplier is idle)
//   A, B    : multiplicand / multiplier, WIDTH bits each
//   result  : 2*WIDTH-bit product, holds the last completed product
//   done    : one-cycle completion pulse
//   busy    : high while an operation is in progress
// Modports: master (requester side), slave (multiplier side).
interface mult_16_if
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic                   init_in;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     result;
    logic                   done;
    logic                   busy;

    modport master (
        output init_in,
        output A,
        output B,
        input  result,
        input  done,
        input  busy
    );

    modport slave (
        input  init_in,
        input  A,
        input  B,
        output result,
        output done,
        output busy
    );

endinterface

// File: rtl/mult_16_control_mult.sv
// control_mult: sequencing FSM for the mult_16 shift-and-add multiplier.
//   clk, rst   : clock, synchronous active-high reset
//   init_in    : start request, honoured only in IDLE
//   mplr_lsb   : current multiplier LSB from the datapath
//   early_stop : datapath reports the remaining multiplier bits are all zero
//   load       : capture operands and clear the accumulator
//   shift      : perform one iteration (shift mcand/mplr)
//   add_en     : add mcand into acc in this iteration
//   finish     : last iteration; datapath latches the product
//   done, busy : handshake status outputs
module control_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic init_in,
    input  logic mplr_lsb,
    input  logic early_stop,
    output logic load,
    output logic shift,
    output logic add_en,
    output logic finish,
    output logic done,
    output logic busy
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        add_en  = 1'b0;
        finish  = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (init_in) begin
                    load    = 1'b1;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                shift  = 1'b1;
                add_en = mplr_lsb;
                cnt_d  = cnt_q - CW'(1);
                // early_stop is tied low unless early exit is compiled in.
                if (cnt_q == CW'(1) || early_stop) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mult_16.sv
// mult_16: sequential shift-and-add unsigned multiplier, result = A * B.
// One multiplier bit is consumed per clock; fixed latency WIDTH+1 cycles
// from the accepted start to the done pulse.
//   clk : system clock (rising edge)
//   rst : synchronous active-high reset, aborts any operation in progress
//   bus : mult_16_if slave modport (init_in, A, B, result, done, busy)
// Optional feature: define MULT_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero (latency = msb index of B + 2).
module mult_16
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    mult_16_if.slave       bus
);

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplr_q,   mplr_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [2*WIDTH-1:0] acc_sum;

    logic load, shift, add_en, finish, early_stop;
    logic done, busy;

`ifdef MULT_EARLY_EXIT_EN
    assign early_stop = ((mplr_q >> 1) == '0);
`else
    assign early_stop = 1'b0;
`endif

    control_mult #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .init_in    (bus.init_in),
        .mplr_lsb   (mplr_q[0]),
        .early_stop (early_stop),
        .load       (load),
        .shift      (shift),
        .add_en     (add_en),
        .finish     (finish),
        .done       (done),
        .busy       (busy)
    );

    // Partial product sum; cannot overflow since A*B < 2^(2*WIDTH).
    assign acc_sum = acc_q + (add_en ? mcand_q : '0);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        result_d = result_q;

        if (load) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, bus.A};
            mplr_d  = bus.B;
        end else if (shift) begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            // Product includes this cycle's add, so latch the sum directly.
            if (finish) begin
                result_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_mult_16.sv
// tb_mult_16: directed, table-driven bench for mult_16 plus hand-written
// sequences for back-to-back starts, start-while-busy and mid-op reset.
module tb_mult_16;

    localparam int unsigned W = 16;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    mult_16_if #(.WIDTH(W)) bus ();

    mult_16 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        int          lat_fixed;
        int          lat_early;
    } vec_t;

    vec_t vecs [7];

    int total = 0;
    int bad   = 0;
    int now_cyc = 0;
    int t0 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        now_cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, now_cyc);
        end
    endtask

    // Drive a one-cycle start; on return we sit in cycle 1 of the operation.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        bus.A       = a;
        bus.B       = b;
        bus.init_in = 1'b1;
        t0          = now_cyc;
        tick();
        bus.init_in = 1'b0;
    endtask

    // Wait (bounded) for done; returns its cycle relative to t0, or -1.
    task automatic wait_done(output int at, output bit busy_ok);
        busy_ok = 1'b1;
        while (!bus.done && (now_cyc - t0) < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
        end
        at = bus.done ? (now_cyc - t0) : -1;
    endtask

    function automatic int pick_lat(input int lf, input int le);
        return EARLY ? le : lf;
    endfunction

    initial begin
        int       at;
        bit       bok;
        int       d1;
        int       dcount;
        int       first_done;
        logic [31:0] held;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F, 17, 4};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 17};
        vecs[2] = '{16'h1234, 16'h0000, 32'h0000_0000, 17, 2};
        vecs[3] = '{16'h0100, 16'h0100, 32'h0001_0000, 17, 10};
        vecs[4] = '{16'h0002, 16'h0001, 32'h0000_0002, 17, 2};
        vecs[5] = '{16'h0005, 16'h8000, 32'h0002_8000, 17, 17};
        vecs[6] = '{16'hABCD, 16'h0003, 32'h0002_0367, 17, 3};

        rst         = 1'b1;
        bus.init_in = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        tick(); tick(); tick();
        check("reset_result", 64'(bus.result), 64'h0);
        check("reset_done",   64'(bus.done),   64'h0);
        check("reset_busy",   64'(bus.busy),   64'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(at, bok);
            check($sformatf("v%0d_latency", i), 64'(at), 64'(pick_lat(vecs[i].lat_fixed, vecs[i].lat_early)));
            check($sformatf("v%0d_result", i),  64'(bus.result), 64'(vecs[i].prod));
            check($sformatf("v%0d_busy_run", i), 64'(bok), 64'h1);
            check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'h0);
            tick();
            check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'h0);
            check($sformatf("v%0d_result_held", i), 64'(bus.result), 64'(vecs[i].prod));
            tick();
        end

        // Back-to-back with init_in held high.
        bus.A       = 16'h1234;
        bus.B       = 16'h0000;
        bus.init_in = 1'b1;
        t0          = now_cyc;
        tick();
        bus.A = 16'h0100;
        bus.B = 16'h0100;
        wait_done(at, bok);
        check("b2b_first_result", 64'(bus.result), 64'h0);
        check("b2b_first_latency", 64'(at), 64'(pick_lat(17, 2)));
        d1 = now_cyc;
        tick();          // DONE -> IDLE
        t0 = now_cyc;    // IDLE cycle that accepts the held start
        tick();
        bus.init_in = 1'b0;
        check("b2b_second_busy", 64'(bus.busy), 64'h1);
        wait_done(at, bok);
        check("b2b_done_gap", 64'(now_cyc - d1), 64'(pick_lat(18, 11)));
        check("b2b_second_result", 64'(bus.result), 64'h0001_0000);
        tick(); tick();

        // Start request while busy must be ignored.
        start_op(16'h0007, 16'h0009);
        dcount     = 0;
        first_done = -1;
        for (int c = 1; c < 45; c++) begin
            if (bus.done) begin
                dcount++;
                if (first_done < 0) first_done = now_cyc - t0;
            end
            if (now_cyc - t0 == 5) begin
                bus.A       = 16'h0002;
                bus.B       = 16'h0002;
                bus.init_in = 1'b1;
            end else begin
                bus.init_in = 1'b0;
            end
            tick();
        end
        bus.init_in = 1'b0;
        check("busy_ign_done_count", 64'(dcount), 64'h1);
        check("busy_ign_latency", 64'(first_done), 64'(pick_lat(17, 5)));
        check("busy_ign_result", 64'(bus.result), 64'd63);

        // Reset in the middle of an operation.
        start_op(16'hAAAA, 16'h5555);
        dcount = 0;
        while (now_cyc - t0 < 8) begin
            if (bus.done) dcount++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_result", 64'(bus.result), 64'h0);
        check("midrst_done",   64'(bus.done),   64'h0);
        check("midrst_busy",   64'(bus.busy),   64'h0);
        for (int c = 0; c < 25; c++) begin
            if (bus.done) dcount++;
            tick();
        end
        check("midrst_no_done", 64'(dcount), 64'h0);
        held = bus.result;
        check("midrst_result_still0", 64'(held), 64'h0);
        start_op(16'h0003, 16'h0005);
        wait_done(at, bok);
        check("post_rst_latency", 64'(at), 64'(pick_lat(17, 4)));
        check("post_rst_result", 64'(bus.result), 64'h0000_000F);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
